colour_status_tx: RTL and testbench
===================================

// Module: colour_status_tx
// PURPOSE
//  Reports the current waveform and background colours back to the host as an ASCII line.
//  Message: "W=rgb B=rgb\r\n". Each of r, g, b is one hex digit, sent red first.
//  Fed by the colour register outputs. Drives the byte-wide valid/ready input of the UART transmitter.
//  It is the reply path to the UART colour-command parser, so the host can read the colours back.
// PARAMETERS
//  HEX_LOWER  0  1: digits a-f are sent lowercase; 0: digits A-F are sent uppercase.
//  SEND_CR    1  1: the line ends in 8'h0D 8'h0A (13 bytes); 0: it ends in 8'h0A only (12 bytes).
// PORTS
//  clk                input   1   system clock; all logic is on its rising edge
//  resetn             input   1   synchronous, active-low reset
//  waveform_colour    input   12  [11:8] blue, [7:4] green, [3:0] red
//  background_colour  input   12  same field layout as waveform_colour
//  report_req         input   1   one-cycle request to send a report
//  tx_ready           input   1   UART transmitter can accept a byte
//  tx_data            output  8   ASCII byte on offer
//  tx_valid           output  1   tx_data is valid
//  busy               output  1   a message is in progress, or a request is pending
// BEHAVIOUR
//  Reset values: tx_valid=0, tx_data=8'h00, busy=0. The FSM goes to IDLE, the byte index to 0, pending to 0.
//    A reset that arrives mid-message aborts it. The rest of the message is never sent; tx_valid=0 the next cycle.
//  States:
//    IDLE: on report_req or pending, copy both colour inputs into a snapshot, clear pending, go to SEND.
//    SEND: tx_valid=1 and tx_data=byte[idx]. A byte transfers on a clk edge where tx_valid&&tx_ready.
//      On transfer, idx increments. On transfer of the last byte, go to DONE.
//    DONE: tx_valid=0 for one cycle, idx=0, then go to IDLE.
//  Latency: report_req sampled high at edge N -> tx_valid=1 with tx_data=8'h57 ('W') after edge N.
//  Handshake:
//    tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0.
//    tx_valid never drops before the byte transfers.
//    When tx_ready is held high, back-to-back bytes go out, one per cycle.
//  Byte order, idx 0..12:
//    'W' '=' Wr Wg Wb ' ' 'B' '=' Br Bg Bb CR LF.
//    With SEND_CR=0 the CR is skipped and the last index is 11.
//  Hex encoding of nibble n:
//    n<=9 -> 8'h30+n.
//    n>=10 -> 8'h37+n (uppercase) or 8'h57+n (HEX_LOWER=1).
//  Snapshot: all digits come from the snapshot. Input changes during a message do not affect the bytes sent.
//  Pending request: a report_req while not in IDLE sets a one-deep pending flag.
//    Further requests while pending=1 are dropped.
//    A pending request starts the next message from IDLE, the cycle after DONE.
//  busy = (state != IDLE) || pending.
// CONFIGURATION
//  COLOUR_AUTO_REPORT_EN
//    Defined:
//      The block keeps a register of the last colours reported, loaded whenever a snapshot is taken.
//      Reset value of that register: waveform 12'h0FF, background 12'h000.
//      In IDLE, any difference between the inputs and the last-reported colours counts as a request.
//      Outside IDLE, a difference sets pending.
//      report_req still works alongside it.
//    Not defined: reports are sent only on report_req. The last-reported register does not exist.
// TESTING
//  1. Reset, then report_req pulse with W=12'h0FF, B=12'h000, tx_ready=1.
//     -> 13 consecutive bytes "W=FF0 B=000\r\n"; tx_valid is 0 on the cycle after LF.
//  2. W=12'hA5C, tx_ready toggled pseudo-randomly.
//     -> "W=C5A ..." is sent; tx_data stays stable across every stall; no byte is lost or duplicated.
//  3. W changes from 12'h0FF to 12'h123 while byte 4 is stalled.
//     -> the message still contains "FF0".
//  4. Three report_req pulses during one message.
//     -> exactly one further message, starting 1 cycle after DONE; busy stays high throughout.
//  5. resetn=0 after byte 6 is accepted.
//     -> tx_valid=0 the next cycle; the next report_req starts again at 'W'.
//  6. HEX_LOWER=1, SEND_CR=0, W=12'hFED.
//     -> "W=def B=000\n" (12 bytes).
//     With COLOUR_AUTO_REPORT_EN defined: changing B to 12'h001 in IDLE, with no report_req,
//     -> "B=100" is sent once, then the block goes idle.

Source files
------------

// File: rtl/colour_status_tx.sv
// Sends "W=rgb B=rgb\r\n" (colour readback) to a byte-wide valid/ready UART transmitter.
// Optional build macro COLOUR_AUTO_REPORT_EN: also report whenever the colours differ from the last report.
module colour_status_tx #(
    parameter int HEX_LOWER = 0,
    parameter int SEND_CR   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] waveform_colour,
    input  logic [11:0] background_colour,
    input  logic        report_req,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a request (or a pending one) to snapshot the colours
    // SEND  | offering byte[idx] to the transmitter
    // DONE  | one quiet cycle after the last byte, index rewound
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = (SEND_CR != 0) ? 4'd12 : 4'd11;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic        pending;
    logic [11:0] snap_w;
    logic [11:0] snap_b;
    logic        colour_diff;
    logic        req_any;
    logic        take_snap;
    logic        xfer;
    logic [7:0]  byte_sel;

    assign req_any   = report_req || colour_diff;
    assign take_snap = (state == IDLE) && (req_any || pending);
    assign xfer      = (state == SEND) && tx_ready;

`ifdef COLOUR_AUTO_REPORT_EN
    logic [11:0] last_w;
    logic [11:0] last_b;

    // Reset value matches the colour register's power-up colours, so no report fires out of reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_w <= 12'h0FF;
            last_b <= 12'h000;
        end else if (take_snap) begin
            last_w <= waveform_colour;
            last_b <= background_colour;
        end
    end

    assign colour_diff = (waveform_colour != last_w) || (background_colour != last_b);
`else
    assign colour_diff = 1'b0;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9)
            return 8'h30 + {4'h0, n};
        else if (HEX_LOWER != 0)
            return 8'h57 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_snap) state_nxt = SEND;
            SEND:    if (xfer && (idx == LAST_IDX)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx     <= 4'd0;
            pending <= 1'b0;
            snap_w  <= 12'h000;
            snap_b  <= 12'h000;
        end else begin
            if (take_snap) begin
                snap_w <= waveform_colour;
                snap_b <= background_colour;
            end
            // One-deep: a request while busy is remembered, any more are dropped.
            if (take_snap)
                pending <= 1'b0;
            else if ((state != IDLE) && req_any)
                pending <= 1'b1;
            if (state == DONE)
                idx <= 4'd0;
            else if (xfer)
                idx <= idx + 4'd1;
        end
    end

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            4'd0:    byte_sel = 8'h57;
            4'd1:    byte_sel = 8'h3D;
            4'd2:    byte_sel = hex_char(snap_w[3:0]);
            4'd3:    byte_sel = hex_char(snap_w[7:4]);
            4'd4:    byte_sel = hex_char(snap_w[11:8]);
            4'd5:    byte_sel = 8'h20;
            4'd6:    byte_sel = 8'h42;
            4'd7:    byte_sel = 8'h3D;
            4'd8:    byte_sel = hex_char(snap_b[3:0]);
            4'd9:    byte_sel = hex_char(snap_b[7:4]);
            4'd10:   byte_sel = hex_char(snap_b[11:8]);
            4'd11:   byte_sel = (SEND_CR != 0) ? 8'h0D : 8'h0A;
            4'd12:   byte_sel = 8'h0A;
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        tx_valid = (state == SEND);
        tx_data  = (state == SEND) ? byte_sel : 8'h00;
        busy     = (state != IDLE) || pending;
    end

endmodule

// File: tb/tb_colour_status_tx.sv
// Bench for colour_status_tx: fixed vector table, hand sequences and random messages vs a string model.
module tb_colour_status_tx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] w_col = 12'h0FF;
    logic [11:0] b_col = 12'h000;
    logic        report_req = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data, tx_data2;
    logic        tx_valid, tx_valid2;
    logic        busy, busy2;

    colour_status_tx dut (
        .clk(clk), .resetn(resetn), .waveform_colour(w_col), .background_colour(b_col),
        .report_req(report_req), .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
    );

    colour_status_tx #(.HEX_LOWER(1), .SEND_CR(0)) dut2 (
        .clk(clk), .resetn(resetn), .waveform_colour(w_col), .background_colour(b_col),
        .report_req(report_req), .tx_ready(tx_ready), .tx_data(tx_data2), .tx_valid(tx_valid2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  cap[$];
    logic [7:0]  cap2[$];
    logic        rst_next = 1'b0;
    logic        req_pulse = 1'b0;
    logic        busy_chk = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    typedef struct {
        logic [11:0]  w;
        logic [11:0]  b;
        int           mode;
        logic [103:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready held low
    task automatic tick(input int mode);
        @(negedge clk);
        resetn     = rst_next;
        report_req = req_pulse;
        req_pulse  = 1'b0;
        tx_ready   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (stalled_prev) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(prev_data));
        end
        stalled_prev = resetn && tx_valid && !tx_ready;
        prev_data    = tx_data;
        if (resetn && tx_valid && tx_ready) cap.push_back(tx_data);
        if (resetn && tx_valid2 && tx_ready) cap2.push_back(tx_data2);
        if (busy_chk) check("busy_high", 32'(busy), 32'd1);
    endtask

    task automatic collect(input int n, input int n2, input int mode, output int cycles);
        cycles = 0;
        while ((cap.size() < n || cap2.size() < n2) && cycles < 400) begin
            tick(mode);
            cycles++;
        end
        if (cycles >= 400) fail_now("collect");
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || busy2) && k < 100) begin
            tick(1);
            k++;
        end
        if (k >= 100) fail_now("wait_idle");
        tick(0);
    endtask

    function automatic string model(input logic [11:0] w, input logic [11:0] b, input bit lower, input bit cr);
        string s;
        s = $sformatf("W=%h%h%h B=%h%h%h", w[3:0], w[7:4], w[11:8], b[3:0], b[7:4], b[11:8]);
        if (!lower) s = s.toupper();
        s = {s, cr ? "\r\n" : "\n"};
        return s;
    endfunction

    task automatic check_msg(input string name, input logic [7:0] q[$], input int off, input string exp);
        for (int i = 0; i < exp.len(); i++) begin
            if (off + i < q.size())
                check($sformatf("%s[%0d]", name, i), 32'(q[off + i]), 32'(exp[i]));
            else
                check($sformatf("%s[%0d]_missing", name, i), 32'd0, 32'(exp[i]) + 32'h100);
        end
    endtask

    initial begin
        int cyc;
        string s;
        vecs[0] = '{12'h0FF, 12'h000, 0, "W=FF0 B=000\r\n"};
        vecs[1] = '{12'hA5C, 12'h3E7, 1, "W=C5A B=7E3\r\n"};
        vecs[2] = '{12'hFFF, 12'h000, 1, "W=FFF B=000\r\n"};
        vecs[3] = '{12'h9A0, 12'hB1F, 1, "W=0A9 B=F1B\r\n"};
        vecs[4] = '{12'h123, 12'hFED, 0, "W=321 B=DEF\r\n"};

        // reset state
        repeat (3) tick(0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_next = 1'b1;
        repeat (2) tick(0);
        check("idle_valid", 32'(tx_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // first message: 13 back-to-back bytes, first on the cycle after the request edge
        cap.delete(); cap2.delete();
        req_pulse = 1'b1;
        tick(0);
        check("t1_pre_valid", 32'(tx_valid), 32'd0);
        collect(13, 0, 0, cyc);
        check("t1_cycles", 32'(cyc), 32'd13);
        check_msg("t1", cap, 0, "W=FF0 B=000\r\n");
        tick(0);
        check("t1_after_lf_valid", 32'(tx_valid), 32'd0);

        // vector table
        foreach (vecs[v]) begin
            wait_idle();
            cap.delete(); cap2.delete();
            w_col = vecs[v].w;
            b_col = vecs[v].b;
            req_pulse = 1'b1;
            tick(vecs[v].mode);
            collect(13, 0, vecs[v].mode, cyc);
            for (int i = 0; i < 13; i++)
                check($sformatf("vec%0d[%0d]", v, i), 32'(cap[i]), 32'(vecs[v].exp[8*(12-i) +: 8]));
            repeat (3) tick(vecs[v].mode);
            check($sformatf("vec%0d_len", v), 32'(cap.size()), 32'd13);
        end

        // inputs change while byte 4 is stalled
        wait_idle();
        cap.delete(); cap2.delete();
        w_col = 12'h0FF; b_col = 12'h000;
        req_pulse = 1'b1;
        tick(0);
        collect(4, 0, 0, cyc);
        tick(2);
        w_col = 12'h123;
        repeat (3) tick(2);
        collect(13, 0, 0, cyc);
        check_msg("t3", cap, 0, "W=FF0 B=000\r\n");

        // three requests during one message -> exactly one follow-up
        wait_idle();
        cap.delete(); cap2.delete();
        w_col = 12'h5A3; b_col = 12'h0C1;
        req_pulse = 1'b1;
        tick(0);
        busy_chk = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t == 2 || t == 5 || t == 8) req_pulse = 1'b1;
            tick(0);
        end
        collect(13, 0, 0, cyc);
        tick(0);
        check("t4_done_valid", 32'(tx_valid), 32'd0);
        tick(0);
        check("t4_idle_valid", 32'(tx_valid), 32'd0);
        tick(0);
        check("t4_restart_valid", 32'(tx_valid), 32'd1);
        check("t4_restart_data", 32'(tx_data), 32'h57);
        collect(26, 0, 0, cyc);
        busy_chk = 1'b0;
        check_msg("t4a", cap, 0, model(12'h5A3, 12'h0C1, 1'b0, 1'b1));
        check_msg("t4b", cap, 13, model(12'h5A3, 12'h0C1, 1'b0, 1'b1));
        repeat (2) tick(0);
        check("t4_busy_low", 32'(busy), 32'd0);
        repeat (10) tick(0);
        check("t4_len", 32'(cap.size()), 32'd26);

        // reset mid-message
        wait_idle();
        cap.delete(); cap2.delete();
        w_col = 12'h0FF; b_col = 12'h000;
        req_pulse = 1'b1;
        tick(0);
        collect(7, 0, 0, cyc);
        rst_next = 1'b0;
        tick(0);
        rst_next = 1'b1;
        tick(0);
        check("t5_valid", 32'(tx_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_len", 32'(cap.size()), 32'd7);
        cap.delete(); cap2.delete();
        req_pulse = 1'b1;
        tick(0);
        collect(13, 0, 0, cyc);
        check_msg("t5", cap, 0, "W=FF0 B=000\r\n");

        // lowercase, LF-only instance
        wait_idle();
        cap.delete(); cap2.delete();
        w_col = 12'hFED; b_col = 12'h000;
        req_pulse = 1'b1;
        tick(1);
        collect(0, 12, 1, cyc);
        check_msg("t6", cap2, 0, "W=def B=000\n");
        repeat (3) tick(1);
        check("t6_len", 32'(cap2.size()), 32'd12);

`ifdef COLOUR_AUTO_REPORT_EN
        wait_idle();
        cap.delete(); cap2.delete();
        b_col = 12'h001;
        collect(0, 12, 0, cyc);
        check_msg("t6_auto", cap2, 0, "W=def B=100\n");
        repeat (30) tick(0);
        check("t6_auto_len", 32'(cap2.size()), 32'd12);
        check("t6_auto_busy", 32'(busy2), 32'd0);
`endif

        // random colours and handshake against the string model
        for (int r = 0; r < 12; r++) begin
            wait_idle();
            cap.delete(); cap2.delete();
            w_col = 12'($urandom);
            b_col = 12'($urandom);
            req_pulse = 1'b1;
            tick(1);
            collect(13, 12, 1, cyc);
            s = model(w_col, b_col, 1'b0, 1'b1);
            check_msg($sformatf("rnd%0d", r), cap, 0, s);
            s = model(w_col, b_col, 1'b1, 1'b0);
            check_msg($sformatf("rnd%0d_lc", r), cap2, 0, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
